// File: rtl/pipe_ctrl_pkg.sv
// Shared stall encodings and multi-cycle sequencer state codes for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    // bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1 = hold
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } mc_state_t;

endpackage

// File: rtl/pipe_ctrl_mc_seq.sv
// EX multi-cycle sequencer: holds EX for exactly len cycles (start cycle included), then pulses done.
//   state | meaning
//   IDLE  | no op in flight; a start with len>=1 and no flush is accepted
//   BUSY  | counting down remaining hold cycles in cnt
//   DONE  | hold released; EX result may advance this cycle
module pipe_ctrl_mc_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_LEN_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MC_LEN_W-1:0] len,
    input  logic                flush_req,
    output logic                hold,
    output logic                busy,
    output logic                done,
    output logic                abort
);

    localparam logic [MC_LEN_W-1:0] ONE = MC_LEN_W'(1);

    mc_state_t           state;
    mc_state_t           state_nxt;
    logic [MC_LEN_W-1:0] cnt;
    logic [MC_LEN_W-1:0] cnt_nxt;
    logic                accept;

    assign accept = (state == MC_IDLE) && start && (len != '0) && !flush_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts wall cycles; upstream stalls never freeze it
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            MC_IDLE: begin
                if (accept) begin
                    cnt_nxt   = len - ONE;
                    state_nxt = (len == ONE) ? MC_DONE : MC_BUSY;
                end
            end
            MC_BUSY: begin
                if (flush_req) begin
                    state_nxt = MC_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - ONE;
                    if (cnt == ONE) begin
                        state_nxt = MC_DONE;
                    end
                end
            end
            MC_DONE: begin
                state_nxt = MC_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = MC_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        hold  = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        abort = 1'b0;
        if (!rst) begin
            hold  = accept || (state == MC_BUSY);
            busy  = (state == MC_BUSY);
            done  = (state == MC_DONE) && !flush_req;
            abort = ((state == MC_BUSY) || (state == MC_DONE)) && flush_req;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, flush redirect and the EX multi-cycle hold
// into one stall vector, and counts stalled cycles with a saturating counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_LEN_W = 6,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                flush_req,
    input  logic [31:0]         flush_pc,
    input  logic                ex_mc_start,
    input  logic [MC_LEN_W-1:0] ex_mc_len,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                ex_mc_busy,
    output logic                ex_mc_done,
    output logic                ex_mc_abort,
    output logic [PERF_W-1:0]   perf_stall_cnt
);

    logic mc_hold;

    pipe_ctrl_mc_seq #(
        .MC_LEN_W (MC_LEN_W)
    ) u_mc_seq (
        .clk       (clk),
        .rst       (rst),
        .start     (ex_mc_start),
        .len       (ex_mc_len),
        .flush_req (flush_req),
        .hold      (mc_hold),
        .busy      (ex_mc_busy),
        .done      (ex_mc_done),
        .abort     (ex_mc_abort)
    );

    always_comb begin
        stall  = STALL_NONE;
        flush  = 1'b0;
        new_pc = 32'h0;
        if (!rst) begin
            if (flush_req) begin
                flush  = 1'b1;
                new_pc = flush_pc;
            end else if (stallreq_mem) begin
                stall = STALL_MEM;
            end else if (stallreq_ex || mc_hold) begin
                stall = STALL_EX;
            end else if (stallreq_id) begin
                stall = STALL_ID;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (stall[0] && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, multi-cycle sequencing, flush abort, async reset
// and perf counter saturation on a narrow-counter instance.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        stallreq_mem = 1'b0;
    logic        flush_req = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        ex_mc_start = 1'b0;
    logic [5:0]  ex_mc_len = 6'd0;

    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        ex_mc_busy;
    logic        ex_mc_done;
    logic        ex_mc_abort;
    logic [31:0] perf_stall_cnt;

    logic [5:0]  s_stall;
    logic        s_flush;
    logic [31:0] s_new_pc;
    logic        s_busy;
    logic        s_done;
    logic        s_abort;
    logic [3:0]  s_perf;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_perf = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MC_LEN_W(6), .PERF_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .flush_req      (flush_req),
        .flush_pc       (flush_pc),
        .ex_mc_start    (ex_mc_start),
        .ex_mc_len      (ex_mc_len),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .ex_mc_busy     (ex_mc_busy),
        .ex_mc_done     (ex_mc_done),
        .ex_mc_abort    (ex_mc_abort),
        .perf_stall_cnt (perf_stall_cnt)
    );

    pipe_ctrl #(.MC_LEN_W(6), .PERF_W(4)) dut_s (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .flush_req      (flush_req),
        .flush_pc       (flush_pc),
        .ex_mc_start    (ex_mc_start),
        .ex_mc_len      (ex_mc_len),
        .stall          (s_stall),
        .flush          (s_flush),
        .new_pc         (s_new_pc),
        .ex_mc_busy     (s_busy),
        .ex_mc_done     (s_done),
        .ex_mc_abort    (s_abort),
        .perf_stall_cnt (s_perf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one cycle of inputs, check outputs mid-cycle, then advance past the next edge
    task automatic cyc(input string tag, input logic sid, input logic sex, input logic smem,
                       input logic fr, input logic [31:0] fpc, input logic st, input logic [5:0] len,
                       input logic [5:0] e_stall, input logic e_busy, input logic e_done,
                       input logic e_abort);
        stallreq_id  = sid;
        stallreq_ex  = sex;
        stallreq_mem = smem;
        flush_req    = fr;
        flush_pc     = fpc;
        ex_mc_start  = st;
        ex_mc_len    = len;
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".flush"}, 32'(flush), 32'(fr));
        chk({tag, ".new_pc"}, new_pc, fr ? fpc : 32'h0);
        chk({tag, ".busy"}, 32'(ex_mc_busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(ex_mc_done), 32'(e_done));
        chk({tag, ".abort"}, 32'(ex_mc_abort), 32'(e_abort));
        chk({tag, ".perf"}, perf_stall_cnt, 32'(exp_perf));
        if (e_stall[0]) exp_perf++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset asserted: outputs forced to zero even with active requests
        #2;
        rst = 1'b1;
        stallreq_mem = 1'b1;
        flush_req    = 1'b1;
        flush_pc     = 32'hdead_beef;
        #1;
        chk("rst.stall", 32'(stall), 32'h0);
        chk("rst.flush", 32'(flush), 32'h0);
        chk("rst.new_pc", new_pc, 32'h0);
        chk("rst.busy", 32'(ex_mc_busy), 32'h0);
        chk("rst.done", 32'(ex_mc_done), 32'h0);
        chk("rst.abort", 32'(ex_mc_abort), 32'h0);
        chk("rst.perf", perf_stall_cnt, 32'h0);
        chk("rst.sperf", 32'(s_perf), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // plain stall priority
        cyc("id",        1, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000111, 0, 0, 0);
        cyc("id_mem",    1, 0, 1, 0, 32'h0,      0, 6'd0, 6'b011111, 0, 0, 0);
        cyc("ex",        0, 1, 0, 0, 32'h0,      0, 6'd0, 6'b001111, 0, 0, 0);
        cyc("ex_id",     1, 1, 0, 0, 32'h0,      0, 6'd0, 6'b001111, 0, 0, 0);
        cyc("idle",      0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 0, 0);
        cyc("flush_pri", 1, 1, 1, 1, 32'h1234,   0, 6'd0, 6'b000000, 0, 0, 0);

        // len=5: five hold cycles then done
        cyc("mc5_t0",    0, 0, 0, 0, 32'h0,      1, 6'd5, 6'b001111, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc("mc5_busy", 0, 0, 0, 0, 32'h0,   0, 6'd0, 6'b001111, 1, 0, 0);
        cyc("mc5_done",  0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 1, 0);
        cyc("mc5_after", 0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 0, 0);

        // len=1 and len=0
        cyc("mc1_t0",    0, 0, 0, 0, 32'h0,      1, 6'd1, 6'b001111, 0, 0, 0);
        cyc("mc1_done",  0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 1, 0);
        cyc("mc0_t0",    0, 0, 0, 0, 32'h0,      1, 6'd0, 6'b000000, 0, 0, 0);
        cyc("mc0_next",  0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 0, 0);

        // MEM stall overlapping BUSY does not freeze the count
        cyc("mc3_t0",    0, 0, 0, 0, 32'h0,      1, 6'd3, 6'b001111, 0, 0, 0);
        cyc("mc3_mem1",  0, 0, 1, 0, 32'h0,      0, 6'd0, 6'b011111, 1, 0, 0);
        cyc("mc3_mem2",  0, 0, 1, 0, 32'h0,      0, 6'd0, 6'b011111, 1, 0, 0);
        cyc("mc3_done",  0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 1, 0);

        // start while BUSY is ignored
        cyc("mc2_t0",    0, 0, 0, 0, 32'h0,      1, 6'd2, 6'b001111, 0, 0, 0);
        cyc("mc2_rest",  0, 0, 0, 0, 32'h0,      1, 6'd9, 6'b001111, 1, 0, 0);
        cyc("mc2_done",  0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 1, 0);
        cyc("mc2_after", 0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 0, 0);

        // flush together with start in IDLE: start not accepted
        cyc("fl_idle",   0, 0, 0, 1, 32'h40,     1, 6'd4, 6'b000000, 0, 0, 0);
        cyc("fl_idle_n", 0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 0, 0);

        // flush at third BUSY cycle aborts the op
        cyc("ab_t0",     0, 0, 0, 0, 32'h0,      1, 6'd5, 6'b001111, 0, 0, 0);
        cyc("ab_b1",     0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b001111, 1, 0, 0);
        cyc("ab_b2",     0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b001111, 1, 0, 0);
        cyc("ab_b3",     0, 0, 0, 1, 32'h20,     0, 6'd0, 6'b000000, 1, 0, 1);
        cyc("ab_n1",     0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 0, 0);
        cyc("ab_n2",     0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 0, 0);

        // flush landing on DONE suppresses done
        cyc("abd_t0",    0, 0, 0, 0, 32'h0,      1, 6'd1, 6'b001111, 0, 0, 0);
        cyc("abd_done",  0, 0, 0, 1, 32'h80,     0, 6'd0, 6'b000000, 0, 0, 1);
        cyc("abd_after", 0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 0, 0);

        // asynchronous reset mid-BUSY
        cyc("ar_t0",     0, 0, 0, 0, 32'h0,      1, 6'd5, 6'b001111, 0, 0, 0);
        cyc("ar_b1",     0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b001111, 1, 0, 0);
        stallreq_id  = 1'b1;
        stallreq_mem = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("ar.stall", 32'(stall), 32'h0);
        chk("ar.flush", 32'(flush), 32'h0);
        chk("ar.new_pc", new_pc, 32'h0);
        chk("ar.busy", 32'(ex_mc_busy), 32'h0);
        chk("ar.done", 32'(ex_mc_done), 32'h0);
        chk("ar.abort", 32'(ex_mc_abort), 32'h0);
        chk("ar.perf", perf_stall_cnt, 32'h0);
        exp_perf = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("ar_post1",  0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 0, 0);
        cyc("ar_post2",  0, 0, 0, 0, 32'h0,      0, 6'd0, 6'b000000, 0, 0, 0);

        // narrow counter saturates at all-ones
        for (int i = 0; i < 14; i++)
            cyc("sat_hold", 1, 0, 0, 0, 32'h0,   0, 6'd0, 6'b000111, 0, 0, 0);
        chk("sat.14", 32'(s_perf), 32'd14);
        cyc("sat_hold", 1, 0, 0, 0, 32'h0,       0, 6'd0, 6'b000111, 0, 0, 0);
        chk("sat.15", 32'(s_perf), 32'd15);
        cyc("sat_hold", 1, 0, 0, 0, 32'h0,       0, 6'd0, 6'b000111, 0, 0, 0);
        chk("sat.15b", 32'(s_perf), 32'd15);
        cyc("sat_end",  0, 0, 0, 0, 32'h0,       0, 6'd0, 6'b000000, 0, 0, 0);
        chk("sat.idle", 32'(s_perf), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
